// File: rtl/step_pkg.sv
// Shared definitions for the step_count producer and its consumers
// (steps_per_min rate calculator, 7-segment path).
package step_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DB_RISE,
        HIGH,
        DB_FALL
    } db_state_t;

    localparam int unsigned CLK_HZ         = 100_000_000;
    localparam int unsigned STEP_MAX_COUNT = 9999;
    localparam int unsigned STEP_COUNT_W   = 16;

endpackage

// File: rtl/step_debounce.sv
// Two-flop synchronizer plus debounce FSM for the pedometer input.
// o_accept is a one-cycle pulse on the edge where a rising level is accepted.
module step_debounce
    import step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pulse,
    output logic o_accept
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    db_state_t       r_state;
    db_state_t       w_state_nx;
    logic [DB_W-1:0] r_db_cnt;
    logic [DB_W-1:0] w_db_cnt_nx;
    logic            w_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pulse;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_db_cnt <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_db_cnt <= w_db_cnt_nx;
        end
    end

    // Accept is Mealy so the counter updates on the same edge the FSM enters HIGH.
    always_comb begin
        w_state_nx  = r_state;
        w_db_cnt_nx = r_db_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_nx  = DB_RISE;
                    w_db_cnt_nx = '0;
                end
            end
            DB_RISE: begin
                if (!r_sync2) begin
                    w_state_nx = IDLE;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nx = HIGH;
                    w_accept   = 1'b1;
                end else begin
                    w_db_cnt_nx = r_db_cnt + DB_W'(1);
                end
            end
            HIGH: begin
                if (!r_sync2) begin
                    w_state_nx  = DB_FALL;
                    w_db_cnt_nx = '0;
                end
            end
            DB_FALL: begin
                if (r_sync2) begin
                    w_state_nx = HIGH;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nx = IDLE;
                end else begin
                    w_db_cnt_nx = r_db_cnt + DB_W'(1);
                end
            end
            default: begin
                w_state_nx  = IDLE;
                w_db_cnt_nx = '0;
            end
        endcase
    end

    assign o_accept = w_accept;

endmodule

// File: rtl/step_counter.sv
// Saturating step counter fed by the debounced pedometer input; drives the
// step_count bus, a per-step strobe and the saturation flag.
module step_counter
    import step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned MAX_COUNT       = STEP_MAX_COUNT,
    parameter int unsigned COUNT_W         = STEP_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pulse_in,
    input  logic               pause,
    input  logic               count_clr,
    output logic [COUNT_W-1:0] step_count,
    output logic               step_strobe,
    output logic               saturated
);

    localparam logic [COUNT_W-1:0] MAX_VAL = COUNT_W'(MAX_COUNT);

    logic               w_accept;
    logic [COUNT_W-1:0] w_count_inc;
    logic [COUNT_W-1:0] r_count;
    logic               r_strobe;
    logic               r_sat;

    step_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .i_pulse  (pulse_in),
        .o_accept (w_accept)
    );

    assign w_count_inc = r_count + COUNT_W'(1);

    // Priority: clear beats pause beats saturation; a cleared or paused step is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_strobe <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (count_clr) begin
                r_count <= '0;
                r_sat   <= 1'b0;
            end else if (w_accept && !pause && (r_count != MAX_VAL)) begin
                r_count  <= w_count_inc;
                r_strobe <= 1'b1;
                r_sat    <= (w_count_inc == MAX_VAL);
            end
        end
    end

    assign step_count  = r_count;
    assign step_strobe = r_strobe;
    assign saturated   = r_sat;

endmodule

// File: doc/step_counter.md
Name: step_counter

Overview:
- Producer side of the 16-bit step_count bus that feeds steps_per_min.
- Takes the raw, asynchronous pedometer sensor/switch pulse and synchronizes it, then debounces it with an FSM.
- Counts one step per debounced rising edge, saturating at a display-safe maximum.
- Provides step_count, a one-cycle step strobe and a saturation flag to the rate calculator and the 7-segment path.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, clk cycles an input level must be stable to be accepted (10 ms at 100 MHz); must be >= 2
MAX_COUNT, 9999, saturation value of step_count (fits 4-digit display)
COUNT_W, 16, width of step_count

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  reset; asynchronous, active-high
pulse_in  input  1  raw sensor/switch level, asynchronous to clk, bouncy
pause  input  1  synchronous; when 1, accepted steps are not counted
count_clr  input  1  synchronous clear of step_count and saturated
step_count  output  COUNT_W  total accepted steps, registered
step_strobe  output  1  one-cycle pulse for each counted step
saturated  output  1  1 while step_count == MAX_COUNT

Behaviour:
- Reset (async assert, sync-safe deassert inside the flops):
  - sync1, sync2 = 0; FSM = IDLE; db_cnt = 0.
  - step_count = 0, step_strobe = 0, saturated = 0.
- Synchronizer: pulse_in -> sync1 -> sync2. All FSM decisions use sync2 only.
- FSM states: IDLE (accepted low), DB_RISE, HIGH (accepted high), DB_FALL.
  - IDLE: sync2=1 -> DB_RISE, db_cnt<=0.
  - DB_RISE: sync2=0 -> IDLE (glitch rejected). Else if db_cnt==DEBOUNCE_CYCLES-1 -> HIGH and assert accept for that edge. Else db_cnt++.
  - HIGH: sync2=0 -> DB_FALL, db_cnt<=0.
  - DB_FALL: sync2=1 -> HIGH. Else if db_cnt==DEBOUNCE_CYCLES-1 -> IDLE. Else db_cnt++.
  - db_cnt width = $clog2(DEBOUNCE_CYCLES); it never exceeds DEBOUNCE_CYCLES-1.
- Counting, on an accept edge with priority count_clr > pause > saturation:
  - count_clr=1: step_count<=0, saturated<=0, no strobe. The step is lost.
  - pause=1: no change, no strobe.
  - step_count==MAX_COUNT: no change, no strobe; saturated stays 1.
  - otherwise: step_count<=step_count+1 and step_strobe<=1 for exactly one cycle. saturated<=1 when the new value == MAX_COUNT.
- count_clr on a non-accept edge clears step_count and saturated; the FSM is unaffected.
- Latency:
  - Number clock edges from 0, where edge 0 is the first edge sampling pulse_in=1.
  - With pulse_in held high, step_count updates and step_strobe rises on edge DEBOUNCE_CYCLES+2.
- Only one step per accepted high period, regardless of how long the level is held.
- A low period shorter than DEBOUNCE_CYCLES inside a high period does not produce a second step.
- Reset mid-debounce discards the partial step. If pulse_in is still high after release, the step is counted after a full debounce from IDLE.
- step_count never wraps. No arithmetic beyond +1 and the compare against MAX_COUNT.

Decomposition:
- Package step_pkg: the FSM state enum (IDLE, DB_RISE, HIGH, DB_FALL), the MAX_COUNT and CLK_HZ constants, and the step-count width localparam shared with steps_per_min.
- One sub-module, step_debounce: holds the synchronizer, FSM and db_cnt, outputs a one-cycle accept.
- step_counter holds the saturating counter and the output flags.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=8 and MAX_COUNT=9999 unless noted.
- Clean pulse: pulse_in high 20 cycles, then low 20 -> step_count 0->1 on edge 10 after the first high sample, step_strobe high exactly 1 cycle; holding high 100 cycles still gives 1.
- Bounce: pulse_in toggles every 3 cycles for 30 cycles, then holds high 20 -> exactly 1 step, counted 10 edges after the final rising sample; glitch of 5 high cycles alone -> 0 steps.
- Dropout: within a high period, a 4-cycle low then high again -> still 1 step total; a following 12-cycle low then high -> step_count=2.
- Saturation (MAX_COUNT=3): 5 clean pulses -> step_count 1,2,3,3,3; saturated=1 after the 3rd; only 3 strobes; count_clr -> step_count=0, saturated=0.
- Pause/clear collision: pause=1 during an accept -> count unchanged, no strobe. count_clr on the accept edge at step_count=7 -> step_count=0, no strobe.
- Async reset: assert rst mid-DB_RISE at step_count=4 -> outputs 0 immediately without a clock edge; with pulse_in still high, deassert -> step_count=1 at edge 10 after release.
